// File: rtl/f8_regbank.sv
// Banked register file with byte-lane writes, write-through next view, bank switching
// and a spill/fill sequencer that copies one bank to or from data memory.
module f8_regbank #(
    parameter int WIDTH  = 16,
    parameter int NREGS  = 3,
    parameter int NBANKS = 2,
    parameter int AW     = 16,
    localparam int RW = (NREGS > 1) ? $clog2(NREGS) : 1,
    localparam int BW = (NBANKS > 1) ? $clog2(NBANKS) : 1,
    localparam int NB = WIDTH / 8
) (
    input  logic                   clk,
    input  logic                   reset,
    output logic [NREGS*WIDTH-1:0] regs_out,
    output logic [NREGS*WIDTH-1:0] next_out,
    input  logic [RW-1:0]          wr_addr,
    input  logic [WIDTH-1:0]       wr_data,
    input  logic [NB-1:0]          wr_en,
    input  logic                   bank_req,
    input  logic [BW-1:0]          bank_sel,
    output logic                   bank_ack,
    output logic [BW-1:0]          active_bank,
    input  logic                   cmd_valid,
    output logic                   cmd_ready,
    input  logic                   cmd_fill,
    input  logic [BW-1:0]          cmd_bank,
    input  logic [AW-1:0]          cmd_base,
    output logic [AW-1:0]          mem_addr,
    output logic [WIDTH-1:0]       mem_wdata,
    output logic [NB-1:0]          mem_wen,
    input  logic [WIDTH-1:0]       mem_rdata,
    output logic                   busy,
    output logic                   done
);

    localparam int KW = $clog2(NREGS + 1);

    typedef enum logic [1:0] {S_IDLE, S_SPILL, S_FILL, S_DONE} state_t;

    state_t           state, state_nxt;
    logic [KW-1:0]    k, k_nxt, km1;
    logic [BW-1:0]    bank_q;
    logic [AW-1:0]    base_q;
    logic             bank_ok_q;
    logic             accept;
    logic             fill_cap;
    logic             wr_ok;
    logic [WIDTH-1:0] regs     [NBANKS][NREGS];
    logic [WIDTH-1:0] regs_nxt [NBANKS][NREGS];

    // Handshakes: a command transfers on cmd_valid && cmd_ready; a bank switch on bank_ack.
    assign busy      = (state != S_IDLE) && !reset;
    assign cmd_ready = (state == S_IDLE) && !reset;
    assign accept    = cmd_valid && cmd_ready;
    assign bank_ack  = bank_req && (state == S_IDLE) && !reset && (int'(bank_sel) < NBANKS);
    assign wr_ok     = int'(wr_addr) < NREGS;
    assign km1       = k - 1'b1;

    always_comb begin
        state_nxt = state;
        k_nxt     = k;
        fill_cap  = 1'b0;
        done      = 1'b0;
        mem_wen   = '0;
        mem_wdata = '0;
        mem_addr  = base_q + AW'(k) * AW'(NB);
        case (state)
            S_IDLE: begin
                if (accept) begin
                    state_nxt = cmd_fill ? S_FILL : S_SPILL;
                    k_nxt     = '0;
                end
            end
            S_SPILL: begin
                mem_wen   = '1;
                mem_wdata = bank_ok_q ? regs[bank_q][k[RW-1:0]] : '0;
                k_nxt     = k + 1'b1;
                if (k == KW'(NREGS - 1)) state_nxt = S_DONE;
            end
            S_FILL: begin
                // Read data lags the address by one cycle, so capture trails by one index.
                fill_cap = (k != '0);
                k_nxt    = k + 1'b1;
                if (k == KW'(NREGS)) state_nxt = S_DONE;
            end
            S_DONE: begin
                done      = 1'b1;
                state_nxt = S_IDLE;
            end
            default: state_nxt = S_IDLE;
        endcase
        if (reset) begin
            mem_wen = '0;
            done    = 1'b0;
        end
    end

    // Fill data first, then core lanes on top so the core wins on its enabled bytes.
    always_comb begin
        regs_nxt = regs;
        if (fill_cap && bank_ok_q) regs_nxt[bank_q][km1[RW-1:0]] = mem_rdata;
        if (wr_ok) begin
            for (int i = 0; i < NB; i++) begin
                if (wr_en[i]) regs_nxt[active_bank][wr_addr][i*8 +: 8] = wr_data[i*8 +: 8];
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state       <= S_IDLE;
            k           <= '0;
            active_bank <= '0;
            bank_q      <= '0;
            base_q      <= '0;
            bank_ok_q   <= 1'b0;
            for (int b = 0; b < NBANKS; b++) begin
                for (int r = 0; r < NREGS; r++) regs[b][r] <= '0;
            end
        end else begin
            state <= state_nxt;
            k     <= k_nxt;
            regs  <= regs_nxt;
            if (bank_ack) active_bank <= bank_sel;
            if (accept) begin
                bank_q    <= cmd_bank;
                base_q    <= cmd_base;
                bank_ok_q <= int'(cmd_bank) < NBANKS;
            end
        end
    end

    for (genvar r = 0; r < NREGS; r++) begin : g_out
        assign regs_out[r*WIDTH +: WIDTH] = regs[active_bank][r];
        assign next_out[r*WIDTH +: WIDTH] = regs_nxt[active_bank][r];
    end

endmodule

// File: tb/tb_f8_regbank.sv
// Bench for f8_regbank: scenario tasks with inline checks plus a scoreboard of
// expected memory writes {addr, data} consumed whenever the DUT writes memory.
module tb_f8_regbank;

    logic        clk = 1'b0;
    logic        reset;
    logic [47:0] regs_out, next_out;
    logic [1:0]  wr_addr;
    logic [15:0] wr_data;
    logic [1:0]  wr_en;
    logic        bank_req;
    logic [0:0]  bank_sel;
    logic        bank_ack;
    logic [0:0]  active_bank;
    logic        cmd_valid, cmd_ready, cmd_fill;
    logic [0:0]  cmd_bank;
    logic [15:0] cmd_base;
    logic [15:0] mem_addr, mem_wdata, mem_rdata;
    logic [1:0]  mem_wen;
    logic        busy, done;

    int          n_tests = 0;
    int          n_fail  = 0;
    logic [31:0] exp_q[$];
    logic [31:0] exp_w;
    logic [15:0] mem_model [logic [15:0]];
    logic [15:0] rd_addr_s = '0;

    f8_regbank #(.WIDTH(16), .NREGS(3), .NBANKS(2), .AW(16)) dut (
        .clk(clk), .reset(reset), .regs_out(regs_out), .next_out(next_out),
        .wr_addr(wr_addr), .wr_data(wr_data), .wr_en(wr_en),
        .bank_req(bank_req), .bank_sel(bank_sel), .bank_ack(bank_ack), .active_bank(active_bank),
        .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_fill(cmd_fill), .cmd_bank(cmd_bank),
        .cmd_base(cmd_base), .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_wen(mem_wen),
        .mem_rdata(mem_rdata), .busy(busy), .done(done)
    );

    always #5 clk = ~clk;

    // Memory model with one cycle of read latency.
    always @(negedge clk) rd_addr_s = mem_addr;
    always @(posedge clk) begin
        #1;
        mem_rdata = mem_model.exists(rd_addr_s) ? mem_model[rd_addr_s] : 16'hdead;
    end

    // Scoreboard: every memory write must match the next expected {addr, data}.
    always @(negedge clk) begin
        if (!reset && mem_wen !== 2'b00) begin
            n_tests++;
            if (exp_q.size() == 0) begin
                n_fail++;
                $display("FAIL mem_write_unexpected: got addr=%h data=%h wen=%b, required no write",
                         mem_addr, mem_wdata, mem_wen);
            end else begin
                exp_w = exp_q.pop_front();
                if ({mem_addr, mem_wdata} !== exp_w || mem_wen !== 2'b11) begin
                    n_fail++;
                    $display("FAIL mem_write: got addr=%h data=%h wen=%b, required addr=%h data=%h wen=11",
                             mem_addr, mem_wdata, mem_wen, exp_w[31:16], exp_w[15:0]);
                end
            end
        end
    end

    function automatic logic [15:0] reg_of(input logic [47:0] v, input int idx);
        return v[idx*16 +: 16];
    endfunction

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic write_reg(input logic [1:0] a, input logic [15:0] d, input logic [1:0] e);
        wr_addr = a; wr_data = d; wr_en = e;
        cyc();
        wr_en = 2'b00;
    endtask

    task automatic test_reset();
        reset = 1'b1; cmd_valid = 1'b1; bank_req = 1'b1; bank_sel = 1'b1;
        cyc(); cyc();
        @(negedge clk);
        n_tests++; if (cmd_ready !== 1'b0) begin n_fail++; $display("FAIL reset_cmd_ready: got %b required 0", cmd_ready); end
        n_tests++; if (bank_ack !== 1'b0) begin n_fail++; $display("FAIL reset_bank_ack: got %b required 0", bank_ack); end
        n_tests++; if (busy !== 1'b0 || done !== 1'b0) begin n_fail++; $display("FAIL reset_busy_done: got %b%b required 00", busy, done); end
        n_tests++; if (mem_wen !== 2'b00) begin n_fail++; $display("FAIL reset_mem_wen: got %b required 00", mem_wen); end
        cyc();
        reset = 1'b0; cmd_valid = 1'b0; bank_req = 1'b0; bank_sel = 1'b0;
        @(negedge clk);
        n_tests++; if (regs_out !== 48'h0) begin n_fail++; $display("FAIL reset_regs: got %h required 0", regs_out); end
        n_tests++; if (active_bank !== 1'b0) begin n_fail++; $display("FAIL reset_active_bank: got %b required 0", active_bank); end
        n_tests++; if (cmd_ready !== 1'b1) begin n_fail++; $display("FAIL idle_cmd_ready: got %b required 1", cmd_ready); end
        cyc();
    endtask

    task automatic test_core_write();
        wr_addr = 2'd1; wr_data = 16'haa55; wr_en = 2'b10;
        @(negedge clk);
        n_tests++; if (reg_of(next_out, 1) !== 16'haa00) begin n_fail++; $display("FAIL write_next_out: got %h required aa00", reg_of(next_out, 1)); end
        n_tests++; if (reg_of(regs_out, 1) !== 16'h0000) begin n_fail++; $display("FAIL write_pre_edge: got %h required 0000", reg_of(regs_out, 1)); end
        cyc();
        wr_en = 2'b00;
        @(negedge clk);
        n_tests++; if (reg_of(regs_out, 1) !== 16'haa00) begin n_fail++; $display("FAIL write_lane_hi: got %h required aa00", reg_of(regs_out, 1)); end
        cyc();
        wr_addr = 2'd3; wr_data = 16'hffff; wr_en = 2'b11;
        @(negedge clk);
        n_tests++; if (next_out !== 48'h0000_aa00_0000) begin n_fail++; $display("FAIL write_oob_next: got %h required 0000aa000000", next_out); end
        cyc();
        wr_en = 2'b00;
        @(negedge clk);
        n_tests++; if (regs_out !== 48'h0000_aa00_0000) begin n_fail++; $display("FAIL write_oob_regs: got %h required 0000aa000000", regs_out); end
        cyc();
        write_reg(2'd0, 16'h0201, 2'b11);
        write_reg(2'd1, 16'h0100, 2'b11);
        write_reg(2'd2, 16'haa55, 2'b11);
        @(negedge clk);
        n_tests++; if (regs_out !== 48'haa55_0100_0201) begin n_fail++; $display("FAIL write_bank0: got %h required aa5501000201", regs_out); end
        cyc();
    endtask

    task automatic test_spill();
        exp_q.push_back(32'h1000_0201);
        exp_q.push_back(32'h1002_0100);
        exp_q.push_back(32'h1004_aa55);
        cmd_valid = 1'b1; cmd_fill = 1'b0; cmd_bank = 1'b0; cmd_base = 16'h1000;
        @(negedge clk);
        n_tests++; if (cmd_ready !== 1'b1) begin n_fail++; $display("FAIL spill_accept: got ready=%b required 1", cmd_ready); end
        cyc();
        cmd_valid = 1'b0;
        for (int c = 1; c <= 4; c++) begin
            @(negedge clk);
            n_tests++; if (done !== (c == 4)) begin n_fail++; $display("FAIL spill_done c%0d: got %b required %b", c, done, (c == 4)); end
            n_tests++; if (busy !== 1'b1) begin n_fail++; $display("FAIL spill_busy c%0d: got %b required 1", c, busy); end
            cyc();
        end
        @(negedge clk);
        n_tests++; if (busy !== 1'b0 || done !== 1'b0) begin n_fail++; $display("FAIL spill_end: got busy=%b done=%b required 0 0", busy, done); end
        n_tests++; if (exp_q.size() != 0) begin n_fail++; $display("FAIL spill_count: got %0d pending writes required 0", exp_q.size()); end
        cyc();
    endtask

    task automatic test_fill_wrap();
        logic [15:0] exp_addr [3];
        int done_cnt;
        exp_addr[0] = 16'hfffe; exp_addr[1] = 16'h0000; exp_addr[2] = 16'h0002;
        done_cnt = 0;
        mem_model[16'hfffe] = 16'h1111;
        mem_model[16'h0000] = 16'h2222;
        mem_model[16'h0002] = 16'h3333;
        cmd_valid = 1'b1; cmd_fill = 1'b1; cmd_bank = 1'b1; cmd_base = 16'hfffe;
        cyc();
        cmd_valid = 1'b0; bank_req = 1'b1; bank_sel = 1'b1;
        for (int c = 1; c <= 5; c++) begin
            @(negedge clk);
            if (done === 1'b1) done_cnt++;
            n_tests++; if (bank_ack !== 1'b0) begin n_fail++; $display("FAIL holdoff_ack c%0d: got %b required 0", c, bank_ack); end
            if (c <= 3) begin
                n_tests++; if (mem_addr !== exp_addr[c-1] || mem_wen !== 2'b00) begin
                    n_fail++; $display("FAIL fill_addr c%0d: got %h wen=%b required %h wen=00", c, mem_addr, mem_wen, exp_addr[c-1]);
                end
            end
            cyc();
        end
        @(negedge clk);
        n_tests++; if (bank_ack !== 1'b1) begin n_fail++; $display("FAIL holdoff_release: got %b required 1", bank_ack); end
        n_tests++; if (done_cnt != 1) begin n_fail++; $display("FAIL fill_done_pulses: got %0d required 1", done_cnt); end
        n_tests++; if (active_bank !== 1'b0) begin n_fail++; $display("FAIL holdoff_bank: got %b required 0", active_bank); end
        cyc();
        bank_req = 1'b0;
        @(negedge clk);
        n_tests++; if (active_bank !== 1'b1) begin n_fail++; $display("FAIL switch_bank: got %b required 1", active_bank); end
        n_tests++; if (regs_out !== 48'h3333_2222_1111) begin n_fail++; $display("FAIL fill_contents: got %h required 333322221111", regs_out); end
        cyc();
    endtask

    task automatic test_fill_conflict();
        mem_model[16'h2000] = 16'h1234;
        mem_model[16'h2002] = 16'h5678;
        mem_model[16'h2004] = 16'h9abc;
        cmd_valid = 1'b1; cmd_fill = 1'b1; cmd_bank = 1'b1; cmd_base = 16'h2000;
        cyc();
        cmd_valid = 1'b0;
        cyc();
        wr_addr = 2'd0; wr_data = 16'hbeef; wr_en = 2'b01;
        @(negedge clk);
        n_tests++; if (reg_of(next_out, 0) !== 16'h12ef) begin n_fail++; $display("FAIL conflict_next: got %h required 12ef", reg_of(next_out, 0)); end
        cyc();
        wr_en = 2'b00;
        cyc(); cyc();
        @(negedge clk);
        n_tests++; if (done !== 1'b1) begin n_fail++; $display("FAIL conflict_done: got %b required 1", done); end
        cyc();
        @(negedge clk);
        n_tests++; if (regs_out !== 48'h9abc_5678_12ef) begin n_fail++; $display("FAIL conflict_regs: got %h required 9abc567812ef", regs_out); end
        n_tests++; if (done !== 1'b0) begin n_fail++; $display("FAIL conflict_done_once: got %b required 0", done); end
        cyc();
    endtask

    task automatic test_reset_abort();
        exp_q.push_back(32'h3000_12ef);
        cmd_valid = 1'b1; cmd_fill = 1'b0; cmd_bank = 1'b1; cmd_base = 16'h3000;
        cyc();
        cmd_valid = 1'b0;
        cyc();
        reset = 1'b1;
        @(negedge clk);
        n_tests++; if (busy !== 1'b0) begin n_fail++; $display("FAIL abort_busy_in_reset: got %b required 0", busy); end
        cyc();
        reset = 1'b0;
        for (int c = 3; c <= 6; c++) begin
            @(negedge clk);
            n_tests++; if (busy !== 1'b0 || done !== 1'b0 || mem_wen !== 2'b00) begin
                n_fail++; $display("FAIL abort_idle c%0d: got busy=%b done=%b wen=%b required 0 0 00", c, busy, done, mem_wen);
            end
            cyc();
        end
        @(negedge clk);
        n_tests++; if (regs_out !== 48'h0 || active_bank !== 1'b0) begin n_fail++; $display("FAIL abort_clear: got regs=%h bank=%b required 0 0", regs_out, active_bank); end
        n_tests++; if (exp_q.size() != 0) begin n_fail++; $display("FAIL abort_first_write: got %0d pending required 0", exp_q.size()); end
        cyc();
        bank_req = 1'b1; bank_sel = 1'b1;
        cyc();
        bank_req = 1'b0;
        @(negedge clk);
        n_tests++; if (active_bank !== 1'b1 || regs_out !== 48'h0) begin n_fail++; $display("FAIL abort_bank1_clear: got bank=%b regs=%h required 1 0", active_bank, regs_out); end
        cyc();
    endtask

    initial begin
        reset = 1'b1; wr_addr = '0; wr_data = '0; wr_en = '0; bank_req = 1'b0; bank_sel = '0;
        cmd_valid = 1'b0; cmd_fill = 1'b0; cmd_bank = '0; cmd_base = '0; mem_rdata = '0;
        test_reset();
        test_core_write();
        test_spill();
        test_fill_wrap();
        test_fill_conflict();
        test_reset_abort();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/f8_regbank.md
Name: f8_regbank

Overview:
- Parametrised successor to the core's fixed three-register file.
- Provides NBANKS banks of NREGS registers, each WIDTH bits wide, with byte-lane write enables and same-cycle write-through "next" outputs.
- Adds single-cycle bank switching, e.g. shadow registers for interrupt entry.
- Adds a spill/fill sequencer that copies a whole bank to or from data memory over a 1-cycle-latency read port and a byte-enabled write port.
- Sits between the cpu decode/ALU datapath and the data-memory arbiter.

Parameters:
WIDTH, 16, register width in bits; must be a multiple of 8.
NREGS, 3, registers per bank (x, y, z in the base configuration).
NBANKS, 2, number of register banks; must be ≥1.
AW, 16, memory address width.

Ports:
clk  in  1  clock; all state updates on posedge.
reset  in  1  synchronous, active-high reset.
regs_out  out  NREGS*WIDTH  active-bank register contents; register k occupies bits [k*WIDTH +: WIDTH].
next_out  out  NREGS*WIDTH  active-bank contents as they will be after this edge's core write (write-through bypass).
wr_addr  in  $clog2(NREGS)  core write register index.
wr_data  in  WIDTH  core write data.
wr_en  in  WIDTH/8  core byte-lane write enables; bit i covers byte i.
bank_req  in  1  request to switch the active bank.
bank_sel  in  $clog2(NBANKS)  bank to make active.
bank_ack  out  1  comb.; bank_req is accepted this cycle.
active_bank  out  $clog2(NBANKS)  current active bank.
cmd_valid  in  1  spill/fill command request.
cmd_ready  out  1  comb.; high when the FSM is IDLE and reset is low.
cmd_fill  in  1  0 = spill (regs→mem), 1 = fill (mem→regs).
cmd_bank  in  $clog2(NBANKS)  bank to copy.
cmd_base  in  AW  byte base address.
mem_addr  out  AW  memory address.
mem_wdata  out  WIDTH  memory write data.
mem_wen  out  WIDTH/8  memory byte write enables.
mem_rdata  in  WIDTH  read data; valid the cycle after mem_addr is presented.
busy  out  1  FSM is not IDLE.
done  out  1  one-cycle pulse when a command completes.

Behaviour:
- Reset (synchronous):
  - All registers in all banks cleared to 0; active_bank = 0; FSM enters IDLE.
  - Outputs during reset: busy = 0, done = 0, mem_wen = 0, cmd_ready = 0, bank_ack = 0.
  - Reset during an operation aborts it immediately; no further memory writes are issued.
- Core write:
  - For each lane i with wr_en[i] set, byte i of register wr_addr in the active bank is updated at posedge.
  - next_out reflects the merged value combinationally in the same cycle.
  - wr_addr ≥ NREGS: ignored.
- Bank switch:
  - bank_ack = bank_req && !busy && !reset; active_bank takes bank_sel at the next edge.
  - A core write in the same cycle targets the old bank.
  - While busy, bank_req is held off (bank_ack = 0); the requester must hold the request.
  - bank_sel ≥ NBANKS: ignored, and bank_ack = 0.
- FSM state IDLE:
  - The command is accepted on cmd_valid && cmd_ready.
  - Command fields are latched; the index counter k is set to 0.
  - The next state is SPILL or FILL.
  - Same-cycle bank_ack and command acceptance are both permitted: the switch applies and the command uses cmd_bank as given.
- FSM state SPILL (NREGS cycles):
  - Each cycle: mem_addr = base + k*(WIDTH/8), mem_wdata = reg[bank][k], mem_wen all ones.
  - k increments each cycle; after k = NREGS-1 the FSM goes to DONE.
- FSM state FILL (NREGS+1 cycles):
  - Cycles 0..NREGS-1 present mem_addr = base + k*(WIDTH/8), with mem_wen = 0.
  - In cycles 1..NREGS, reg[bank][k-1] is written from mem_rdata.
  - After the last capture cycle the FSM goes to DONE.
- FSM state DONE:
  - Exactly one cycle with done = 1, then the FSM returns to IDLE.
  - cmd_ready is 0 in DONE.
- Address arithmetic: modulo 2^AW; wrap is permitted and not flagged.
- Conflicts:
  - The core may write during SPILL; the spilled value is the register content at that register's spill cycle.
  - A fill write and a core write to the same register in the same cycle: the core write wins on its enabled lanes; the fill data supplies the remaining lanes.
- Idle outputs: mem_wen = 0; mem_addr and mem_wdata are don't-care.

Test Plan:
1. Reset, then write wr_addr=1, wr_data=16'haa55, wr_en=2'b10 → next_out[1] = 16'haa00 in the same cycle; regs_out[1] = 16'haa00 after the edge.
2. Spill of bank 0 holding 0201/0100/aa55, base 16'h1000 → writes 0201@1000, 0100@1002, aa55@1004 on consecutive cycles; done pulses in cycle 4 after acceptance.
3. Fill of bank 1 from base 16'hfffe with memory returning 1111/2222/3333 → addresses fffe, 0000, 0002 (wrap); bank 1 ends at 1111/2222/3333; done pulses once.
4. bank_req to bank 1 while busy → bank_ack = 0 until the cycle after DONE; then active_bank = 1 and regs_out shows bank 1 contents.
5. Fill of the active bank with a core write to reg 0 (data beef, wr_en=01) in the capture cycle of mem_rdata=1234 → reg 0 = 12ef.
6. Reset asserted during the second SPILL cycle → mem_wen = 0 from the next cycle; busy = 0, all registers = 0, active_bank = 0.
